dram_cmd_scheduler: RTL and testbench
=====================================

Name: dram_cmd_scheduler

Overview:
- Consumes memory requests from the head of the request FIFO and turns each into a closed-page DDR4 command sequence: ACT, RD/WR, PRE.
- Sits directly downstream of the FIFO, driven by fifo_output, empty and exit_flag.
- Enforces JEDEC timing in DIMM cycles. One DIMM cycle equals CLK_RATIO CPU cycles.
- Services one request at a time; there is no overlap between requests.

Parameters:
- CLK_RATIO, 2: CPU cycles per DIMM cycle; must be ≥1.
- T_RCD, 24: DIMM cycles from ACT to RD/WR.
- T_CL, 24: read CAS latency; informational, used by the trace only.
- T_CWL, 20: write CAS latency.
- T_RAS, 52: minimum DIMM cycles from ACT to PRE.
- T_RTP, 12: minimum DIMM cycles from RD to PRE.
- T_WR, 20: write recovery, counted after the last write data.
- T_BURST, 4: burst duration in DIMM cycles.
- T_RP, 24: DIMM cycles from PRE until the next ACT.

Ports:
- CPU_clock  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- fifo_output  in  parser_out_struct  FIFO head. Fields used: opcode[1:0] and address[32:0].
- empty  in  1  FIFO empty.
- exit_flag  out  1  one-cycle pop strobe to the FIFO.
- cmd_valid  out  1  command issued this cycle.
- cmd_code  out  3  0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE.
- cmd_bg  out  2  bank group.
- cmd_bank  out  2  bank.
- cmd_row  out  15  row.
- cmd_col  out  8  column.
- dimm_cycle  out  64  free-running DIMM cycle count.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Clock and reset: one clock, CPU_clock. rst_n is synchronous and active-low, sampled on posedge CPU_clock.
- Reset values: all outputs 0, cmd_code=NOP, state IDLE, divider 0, dimm_cycle 0.
- DIMM tick:
  - Divider counts 0..CLK_RATIO-1 and wraps.
  - tick is high in the CPU cycle where divider==CLK_RATIO-1.
  - dimm_cycle increments on each tick.
  - Commands are issued only in tick cycles.
  - cmd_valid is high for exactly that one CPU cycle; cmd_code/bg/bank/row/col are valid with it and read NOP/0 otherwise.
- Address decode: row=addr[32:18], col=addr[17:10], bank=addr[9:8], bg=addr[7:6].
- Opcode: 1 means write; 0 and 2 mean read.
- IDLE:
  - If !empty: pulse exit_flag in that same cycle, latch fifo_output into the request register, go to ISSUE_ACT.
  - If empty: exit_flag stays 0.
- ISSUE_ACT: at the next tick, issue ACT. Load the RCD counter with T_RCD and clear the RAS counter. Go to WAIT_RCD.
- WAIT_RCD:
  - The counter decrements per tick.
  - On the tick where T_RCD DIMM cycles have elapsed since ACT, issue RD or WR; the CAS tick is ACT tick + T_RCD.
  - Load the PRE guard: T_RTP for a read; T_CWL+T_BURST+T_WR for a write.
  - Go to WAIT_PRE.
- WAIT_PRE:
  - Issue PRE on the first tick where ticks since ACT ≥ T_RAS and ticks since CAS ≥ guard.
  - Load the RP counter with T_RP. Go to WAIT_RP.
- WAIT_RP: when T_RP ticks since PRE have elapsed, return to IDLE. A pop may occur in that same CPU cycle if !empty.
- Next-request spacing: the earliest next ACT is at tick PRE + T_RP.
- Counters: 8-bit elapsed counters that saturate at 255 and never wrap.
- Empty/full: no pop is issued while not IDLE. exit_flag is never asserted when empty=1.
- Reset mid-sequence: abort immediately. No PRE is issued, the in-flight request is discarded and outputs return to reset values on the next edge.
- Simultaneous events: if empty falls in the same cycle rst_n is low, reset wins and there is no pop.

Optional Feature:
- Macro: SCHED_TRACE_EN.
- When defined, each issued command prints one $display line: "<dimm_cycle> 0 <ACT|RD|WR|PRE> <bg> <bank> <row|col hex>".
  - ACT lines show the row.
  - RD/WR lines show the column.
  - PRE lines show bg and bank only.
- When undefined, no display code is elaborated and RTL behaviour is identical.

Test Plan:
- Reset and idle: hold rst_n=0 for 2 cycles, then release with empty=1 for 50 cycles → exit_flag=0, cmd_valid=0, busy=0, dimm_cycle increments every 2 CPU cycles.
- Single read, address 0x1_2345_6789, opcode 0:
  - exit_flag pulses once.
  - ACT bg=2 bank=3 row=0x48D1 at tick T.
  - RD col=0x59 at T+24.
  - PRE at T+52, where the T_RAS limit dominates.
- Single write, same address, opcode 1: ACT at T, WR at T+24, PRE at T+68 (24+20+4+20), where the write guard dominates.
- Back-to-back reads, FIFO holding 2 entries: the second pop occurs only after WAIT_RP, and the second ACT is exactly at first PRE + 24 ticks.
- Reset mid-operation: assert rst_n=0 one cycle after the RD issues → no PRE; outputs return to 0 next edge; after release, the next queued request starts with a fresh ACT.
- CLK_RATIO=1, single read: ACT/RD/PRE spacing is 24/52 CPU cycles, and cmd_valid is never high on two consecutive cycles.

Source files
------------

// File: rtl/dram_cmd_scheduler.sv
// Closed-page DDR4 command scheduler: pops one request, issues ACT -> RD/WR -> PRE, then waits tRP.
// Latency: ACT on the first DIMM tick after the pop, CAS at ACT+T_RCD, PRE once tRAS and the CAS guard are met.
// Backpressure: pops (exit_flag) only from IDLE or the last tick of tRP, never while empty or in reset.
//
// fifo_output packing: [34:33] opcode, [32:0] address. Address bits [5:0] carry no DRAM coordinate.
// Optional trace: define SCHED_TRACE_EN to print one line per issued command.
// Recovery after PRE must satisfy T_RP >= 2.
module dram_cmd_scheduler #(
    parameter int CLK_RATIO = 2,
    parameter int T_RCD     = 24,
    parameter int T_CL      = 24,
    parameter int T_CWL     = 20,
    parameter int T_RAS     = 52,
    parameter int T_RTP     = 12,
    parameter int T_WR      = 20,
    parameter int T_BURST   = 4,
    parameter int T_RP      = 24
) (
    input  logic        CPU_clock,
    input  logic        rst_n,
    input  logic [34:0] fifo_output,
    input  logic        empty,
    output logic        exit_flag,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic [1:0]  cmd_bg,
    output logic [1:0]  cmd_bank,
    output logic [14:0] cmd_row,
    output logic [7:0]  cmd_col,
    output logic [63:0] dimm_cycle,
    output logic        busy
);

    localparam int DIV_W = (CLK_RATIO > 1) ? $clog2(CLK_RATIO) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_RATIO - 1);

    // Elapsed-tick thresholds, widened by one bit so "count + offset" never overflows.
    localparam logic [8:0] RCD_N = 9'(T_RCD);
    localparam logic [8:0] RAS_N = 9'(T_RAS);
    localparam logic [8:0] RP_N  = 9'(T_RP);
    localparam logic [7:0] RD_GUARD = 8'(T_RTP);
    localparam logic [7:0] WR_GUARD = 8'(T_CWL + T_BURST + T_WR);

    // Read CAS latency only matters to whoever collects read data; the trace reports it.
    localparam int unused_t_cl = T_CL;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_ACT,
        S_WAIT_RCD,
        S_WAIT_PRE,
        S_WAIT_RP
    } state_t;

    state_t state_q, state_d;

    logic [DIV_W-1:0] div_q;
    logic [63:0]      dimm_q;
    logic             tick;

    logic [14:0] req_row_q;
    logic [7:0]  req_col_q;
    logic [1:0]  req_bank_q;
    logic [1:0]  req_bg_q;
    logic        req_wr_q;

    // Elapsed ticks since the last ACT, CAS and PRE respectively (saturating).
    logic [7:0] act_cnt_q;
    logic [7:0] cas_cnt_q;
    logic [7:0] rp_cnt_q;
    logic [7:0] guard_q;

    logic [8:0] act_elapsed;
    logic [8:0] cas_elapsed;
    logic [8:0] rp_lookahead;

    logic pop;
    logic act_fire;
    logic cas_fire;
    logic pre_fire;
    logic rp_done;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^fifo_output[5:0];

    assign tick = (div_q == DIV_MAX);

    // Counters hold k-1 during the tick that is k ticks after their event.
    assign act_elapsed  = {1'b0, act_cnt_q} + 9'd1;
    assign cas_elapsed  = {1'b0, cas_cnt_q} + 9'd1;
    // Recovery ends one tick early so a pop here lets the next ACT land exactly on PRE+T_RP.
    assign rp_lookahead = {1'b0, rp_cnt_q} + 9'd2;

    // DIMM clock divider and free-running DIMM cycle counter.
    always_ff @(posedge CPU_clock) begin
        if (!rst_n) begin
            div_q  <= '0;
            dimm_q <= '0;
        end else if (tick) begin
            div_q  <= '0;
            dimm_q <= dimm_q + 64'd1;
        end else begin
            div_q  <= div_q + DIV_W'(1);
        end
    end

    // Capture the FIFO head and decode DRAM coordinates at the pop.
    always_ff @(posedge CPU_clock) begin
        if (!rst_n) begin
            req_row_q  <= '0;
            req_col_q  <= '0;
            req_bank_q <= '0;
            req_bg_q   <= '0;
            req_wr_q   <= 1'b0;
        end else if (pop) begin
            req_row_q  <= fifo_output[32:18];
            req_col_q  <= fifo_output[17:10];
            req_bank_q <= fifo_output[9:8];
            req_bg_q   <= fifo_output[7:6];
            req_wr_q   <= (fifo_output[34:33] == 2'b01);
        end
    end

    // Elapsed-tick counters: cleared on their command, advance per tick, stick at 255.
    always_ff @(posedge CPU_clock) begin
        if (!rst_n) begin
            act_cnt_q <= '0;
            cas_cnt_q <= '0;
            rp_cnt_q  <= '0;
            guard_q   <= '0;
        end else begin
            if (act_fire)
                act_cnt_q <= '0;
            else if (tick && act_cnt_q != 8'hFF)
                act_cnt_q <= act_cnt_q + 8'd1;

            if (cas_fire) begin
                cas_cnt_q <= '0;
                guard_q   <= req_wr_q ? WR_GUARD : RD_GUARD;
            end else if (tick && cas_cnt_q != 8'hFF) begin
                cas_cnt_q <= cas_cnt_q + 8'd1;
            end

            if (pre_fire)
                rp_cnt_q <= '0;
            else if (tick && rp_cnt_q != 8'hFF)
                rp_cnt_q <= rp_cnt_q + 8'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge CPU_clock) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next-state logic, driven by the event strobes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (pop)      state_d = S_ISSUE_ACT;
            S_ISSUE_ACT: if (act_fire) state_d = S_WAIT_RCD;
            S_WAIT_RCD:  if (cas_fire) state_d = S_WAIT_PRE;
            S_WAIT_PRE:  if (pre_fire) state_d = S_WAIT_RP;
            S_WAIT_RP:   if (rp_done)  state_d = pop ? S_ISSUE_ACT : S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    // FSM outputs: event strobes, command bus (NOP/0 unless issuing), pop and busy.
    always_comb begin
        pop      = 1'b0;
        act_fire = 1'b0;
        cas_fire = 1'b0;
        pre_fire = 1'b0;
        rp_done  = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IDLE:      pop      = !empty;
                S_ISSUE_ACT: act_fire = tick;
                S_WAIT_RCD:  cas_fire = tick && (act_elapsed >= RCD_N);
                S_WAIT_PRE:  pre_fire = tick && (act_elapsed >= RAS_N)
                                             && (cas_elapsed >= {1'b0, guard_q});
                S_WAIT_RP: begin
                    rp_done = tick && (rp_lookahead >= RP_N);
                    pop     = rp_done && !empty;
                end
                default: ;
            endcase
        end

        cmd_valid = act_fire | cas_fire | pre_fire;
        cmd_code  = CMD_NOP;
        cmd_bg    = '0;
        cmd_bank  = '0;
        cmd_row   = '0;
        cmd_col   = '0;
        if (act_fire) begin
            cmd_code = CMD_ACT;
            cmd_bg   = req_bg_q;
            cmd_bank = req_bank_q;
            cmd_row  = req_row_q;
        end else if (cas_fire) begin
            cmd_code = req_wr_q ? CMD_WR : CMD_RD;
            cmd_bg   = req_bg_q;
            cmd_bank = req_bank_q;
            cmd_col  = req_col_q;
        end else if (pre_fire) begin
            cmd_code = CMD_PRE;
            cmd_bg   = req_bg_q;
            cmd_bank = req_bank_q;
        end

        exit_flag  = pop;
        busy       = (state_q != S_IDLE);
        dimm_cycle = dimm_q;
    end

`ifdef SCHED_TRACE_EN
    // Command trace: one line per issued command, stamped with the DIMM cycle.
    always_ff @(posedge CPU_clock) begin
        if (cmd_valid) begin
            case (cmd_code)
                CMD_ACT: $display("%0d 0 ACT %0d %0d %h", dimm_cycle, cmd_bg, cmd_bank, cmd_row);
                CMD_RD:  $display("%0d 0 RD %0d %0d %h (CL %0d)", dimm_cycle, cmd_bg, cmd_bank, cmd_col, unused_t_cl);
                CMD_WR:  $display("%0d 0 WR %0d %0d %h", dimm_cycle, cmd_bg, cmd_bank, cmd_col);
                default: $display("%0d 0 PRE %0d %0d", dimm_cycle, cmd_bg, cmd_bank);
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench for dram_cmd_scheduler: a CLK_RATIO=2 instance under directed and random traffic,
// plus a CLK_RATIO=1 instance for single-cycle tick spacing.
// Expected pops/commands are timestamped arithmetically at push time; a monitor pops and compares.
module tb_dram_cmd_scheduler;

    localparam int T_RCD = 24, T_CWL = 20, T_RAS = 52, T_RTP = 12;
    localparam int T_WR = 20, T_BURST = 4, T_RP = 24;

    typedef struct {
        logic [1:0]  op;
        logic [32:0] addr;
    } req_t;

    typedef struct {
        int code;
        int tick;
        int bg;
        int bank;
        int row;
        int col;
    } exp_cmd_t;

    logic CPU_clock = 1'b0;
    logic rst_n = 1'b0;

    logic [34:0] fifo_output = '0, fifo_output1 = '0;
    logic        empty = 1'b1, empty1 = 1'b1;
    logic        exit_flag, exit_flag1;
    logic        cmd_valid, cmd_valid1;
    logic [2:0]  cmd_code, cmd_code1;
    logic [1:0]  cmd_bg, cmd_bg1, cmd_bank, cmd_bank1;
    logic [14:0] cmd_row, cmd_row1;
    logic [7:0]  cmd_col, cmd_col1;
    logic [63:0] dimm_cycle, dimm_cycle1;
    logic        busy, busy1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int free0 = 0, free1 = 0;
    logic prev_v1 = 1'b0;
    logic saw_cas = 1'b0;

    req_t     fq[$], q1[$];
    int       exp_pop0[$], exp_pop1[$];
    exp_cmd_t exp_cmd0[$], exp_cmd1[$];

    always #5 CPU_clock = ~CPU_clock;

    // Cycle index since reset release; equals the DUT's CPU-cycle position in the DIMM divider.
    always @(posedge CPU_clock) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    dram_cmd_scheduler #(
        .CLK_RATIO(2), .T_RCD(T_RCD), .T_CL(24), .T_CWL(T_CWL), .T_RAS(T_RAS),
        .T_RTP(T_RTP), .T_WR(T_WR), .T_BURST(T_BURST), .T_RP(T_RP)
    ) u_dut (
        .CPU_clock(CPU_clock), .rst_n(rst_n), .fifo_output(fifo_output), .empty(empty),
        .exit_flag(exit_flag), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bg(cmd_bg),
        .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col), .dimm_cycle(dimm_cycle),
        .busy(busy)
    );

    dram_cmd_scheduler #(
        .CLK_RATIO(1), .T_RCD(T_RCD), .T_CL(24), .T_CWL(T_CWL), .T_RAS(T_RAS),
        .T_RTP(T_RTP), .T_WR(T_WR), .T_BURST(T_BURST), .T_RP(T_RP)
    ) u_dut1 (
        .CPU_clock(CPU_clock), .rst_n(rst_n), .fifo_output(fifo_output1), .empty(empty1),
        .exit_flag(exit_flag1), .cmd_valid(cmd_valid1), .cmd_code(cmd_code1), .cmd_bg(cmd_bg1),
        .cmd_bank(cmd_bank1), .cmd_row(cmd_row1), .cmd_col(cmd_col1), .dimm_cycle(dimm_cycle1),
        .busy(busy1)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: pop when both the request and the scheduler are available, ACT on the
    // first tick after the pop, CAS tRCD later, PRE at max(ACT+tRAS, CAS+guard), next ACT >= PRE+tRP.
    task automatic model_req(input int inst, input req_t rq, input int arr);
        int r, fr, pop, act, cas, pre, guard;
        exp_cmd_t e;
        r   = (inst == 1) ? 1 : 2;
        fr  = (inst == 1) ? free1 : free0;
        pop = (arr > fr) ? arr : fr;
        act = (pop + 1) / r;
        cas = act + T_RCD;
        guard = (rq.op == 2'd1) ? (T_CWL + T_BURST + T_WR) : T_RTP;
        pre = act + T_RAS;
        if (cas + guard > pre) pre = cas + guard;
        fr = (pre + T_RP) * r - 1;
        e.bg = int'(rq.addr[7:6]);
        e.bank = int'(rq.addr[9:8]);
        if (inst == 1) begin free1 = fr; exp_pop1.push_back(pop); end
        else           begin free0 = fr; exp_pop0.push_back(pop); end
        e.code = 1; e.tick = act; e.row = int'(rq.addr[32:18]); e.col = 0;
        if (inst == 1) exp_cmd1.push_back(e); else exp_cmd0.push_back(e);
        e.code = (rq.op == 2'd1) ? 3 : 2; e.tick = cas; e.row = 0; e.col = int'(rq.addr[17:10]);
        if (inst == 1) exp_cmd1.push_back(e); else exp_cmd0.push_back(e);
        e.code = 4; e.tick = pre; e.row = 0; e.col = 0;
        if (inst == 1) exp_cmd1.push_back(e); else exp_cmd0.push_back(e);
    endtask

    task automatic present();
        empty        = (fq.size() == 0);
        fifo_output  = empty  ? '0 : {fq[0].op, fq[0].addr};
        empty1       = (q1.size() == 0);
        fifo_output1 = empty1 ? '0 : {q1[0].op, q1[0].addr};
    endtask

    task automatic step();
        @(negedge CPU_clock);
        present();
    endtask

    task automatic push_req(input int inst, input logic [1:0] op, input logic [32:0] addr);
        req_t rq;
        rq.op = op;
        rq.addr = addr;
        if (inst == 1) q1.push_back(rq); else fq.push_back(rq);
        model_req(inst, rq, cyc);
        present();
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (!(fq.size() == 0 && exp_pop0.size() == 0 && exp_cmd0.size() == 0 &&
                 q1.size() == 0 && exp_pop1.size() == 0 && exp_cmd1.size() == 0 &&
                 !busy && !busy1) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", (n >= budget) ? 1 : 0, 0);
    endtask

    task automatic mon_inst(input int inst, input logic ex, input logic em, input logic v,
                            input logic [2:0] code, input logic [1:0] bg, input logic [1:0] bank,
                            input logic [14:0] row, input logic [7:0] col, input logic bsy);
        string    p;
        int       r, exp_p;
        exp_cmd_t e;
        p = (inst == 1) ? "r1_" : "r2_";
        r = (inst == 1) ? 1 : 2;
        if (ex) begin
            chk({p, "pop_when_empty"}, em, 0);
            if ((inst == 1 ? exp_pop1.size() : exp_pop0.size()) == 0) begin
                chk({p, "unexpected_pop"}, 1, 0);
            end else begin
                exp_p = (inst == 1) ? exp_pop1.pop_front() : exp_pop0.pop_front();
                chk({p, "pop_cycle"}, cyc, exp_p);
            end
            if (inst == 1) begin if (q1.size() > 0) q1.delete(0); end
            else           begin if (fq.size() > 0) fq.delete(0); end
        end
        if (v) begin
            chk({p, "busy_at_cmd"}, bsy, 1);
            if (inst == 0 && (code == 3'd2 || code == 3'd3)) saw_cas = 1'b1;
            if ((inst == 1 ? exp_cmd1.size() : exp_cmd0.size()) == 0) begin
                chk({p, "unexpected_cmd"}, code, 0);
            end else begin
                e = (inst == 1) ? exp_cmd1.pop_front() : exp_cmd0.pop_front();
                chk({p, "cmd_code"}, code, e.code);
                chk({p, "cmd_cycle"}, cyc, e.tick * r + r - 1);
                chk({p, "cmd_bg"}, bg, e.bg);
                chk({p, "cmd_bank"}, bank, e.bank);
                chk({p, "cmd_row"}, row, e.row);
                chk({p, "cmd_col"}, col, e.col);
            end
        end else begin
            chk({p, "nop_fields"}, {code, bg, bank, row, col}, 0);
        end
        if (inst == 1) begin
            if (v) chk("r1_back_to_back_valid", prev_v1, 0);
            prev_v1 = v;
        end
    endtask

    // Monitor: samples mid-cycle, after the driver has settled this cycle's inputs.
    always @(negedge CPU_clock) begin
        #1;
        if (!rst_n) begin
            chk("rst_exit_flag", exit_flag, 0);
            chk("rst_cmd_valid", cmd_valid, 0);
            chk("rst_exit_flag1", exit_flag1, 0);
            chk("rst_cmd_valid1", cmd_valid1, 0);
            prev_v1 = 1'b0;
        end else begin
            chk("dimm_cycle", dimm_cycle, cyc / 2);
            chk("dimm_cycle1", dimm_cycle1, cyc);
            mon_inst(0, exit_flag, empty, cmd_valid, cmd_code, cmd_bg, cmd_bank, cmd_row, cmd_col, busy);
            mon_inst(1, exit_flag1, empty1, cmd_valid1, cmd_code1, cmd_bg1, cmd_bank1, cmd_row1, cmd_col1, busy1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gap;

        // Reset, then 50 idle cycles with the FIFO empty.
        repeat (2) @(posedge CPU_clock);
        step();
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_dimm", dimm_cycle, 0);
        chk("rst_code", cmd_code, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            #1;
            chk("idle_busy", busy, 0);
            chk("idle_exit", exit_flag, 0);
            chk("idle_valid", cmd_valid, 0);
        end

        // Directed single read on both instances, then a write, then two queued reads.
        step();
        push_req(0, 2'd0, 33'h1_2345_6789);
        push_req(1, 2'd0, 33'h1_2345_6789);
        wait_drain(3000);
        step();
        push_req(0, 2'd1, 33'h1_2345_6789);
        wait_drain(3000);
        step();
        push_req(0, 2'd2, {1'b0, $urandom});
        push_req(0, 2'd0, {1'b1, $urandom});
        wait_drain(3000);

        // Randomized traffic: mixed gaps, including same-cycle and mid-sequence arrivals.
        for (int i = 0; i < 8; i++) begin
            gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 300);
            repeat (gap) step();
            push_req(0, 2'($urandom_range(0, 2)), {1'($urandom_range(0, 1)), $urandom});
        end
        wait_drain(12000);

        // Reset one cycle after a RD: no PRE, in-flight request dropped, queued one restarts.
        step();
        saw_cas = 1'b0;
        push_req(0, 2'd0, {1'b0, $urandom});
        push_req(0, 2'd1, {1'b1, $urandom});
        n = 0;
        while (!saw_cas && n < 2000) begin
            step();
            n++;
        end
        chk("cas_timeout", (n >= 2000) ? 1 : 0, 0);
        rst_n = 1'b0;
        exp_cmd0.delete();
        exp_pop0.delete();
        free0 = 0;
        step();
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_dimm", dimm_cycle, 0);
        chk("midrst_valid", cmd_valid, 0);
        chk("midrst_exit", exit_flag, 0);
        step();
        rst_n = 1'b1;
        foreach (fq[i]) model_req(0, fq[i], cyc);
        wait_drain(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
